// File: rtl/fre_generate_pkg.sv
// Shared constants and FSM state type for the square-wave generator.
// Pure declarations; no timing or flow-control behaviour of its own.
package fre_pkg;

    localparam int DIV_W_DEF = 32;
    localparam int FREQ_W    = 20;
    localparam int KHZ_X2    = 2000;
    localparam int KHZ_X1    = 1000;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        DIV  = 2'd1,
        RUN  = 2'd2
    } fre_state_t;

endpackage

// File: rtl/fre_generate_if.sv
// Frequency request channel: valid/ready handshake plus the requested kHz value.
// The slave holds ready low while a division is in flight; the master keeps valid and data stable until accepted.
interface fre_generate_if;
    import fre_pkg::*;

    logic              cfg_valid_i;
    logic              cfg_ready_o;
    logic [FREQ_W-1:0] freq_khz_i;

    modport master (output cfg_valid_i, output freq_khz_i, input cfg_ready_o);
    modport slave  (input cfg_valid_i, input freq_khz_i, output cfg_ready_o);

endinterface

// File: rtl/fre_generate_div_seq.sv
// Unsigned restoring divider: the first quotient bit is resolved on the start edge, done pulses with the full quotient W cycles later.
// No backpressure: start is ignored while busy, and done is a single-cycle pulse the caller must catch.
module fre_div_seq #(
    parameter int W = 32
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         start,
    input  logic [W-1:0] dividend,
    input  logic [W-1:0] divisor,
    output logic         done,
    output logic [W-1:0] quotient
);

    localparam int CNT_W = $clog2(W) + 1;

    logic [W-1:0]     rem;
    logic [W-1:0]     quo;
    logic [W-1:0]     dvs;
    logic [CNT_W-1:0] cnt;
    logic             busy;

    // One restoring step: shift the next dividend bit into the remainder, subtract if it fits.
    function automatic logic [2*W-1:0] div_step(input logic [W-1:0] r,
                                                input logic [W-1:0] q,
                                                input logic [W-1:0] d);
        logic [W:0] t;
        t = {r, q[W-1]};
        if (t >= {1'b0, d}) begin
            t = t - {1'b0, d};
            return {t[W-1:0], q[W-2:0], 1'b1};
        end
        return {t[W-1:0], q[W-2:0], 1'b0};
    endfunction

    always_ff @(posedge clk) begin
        if (rst) begin
            rem  <= '0;
            quo  <= '0;
            dvs  <= '0;
            cnt  <= '0;
            busy <= 1'b0;
            done <= 1'b0;
        end else begin
            done <= 1'b0;
            if (!busy) begin
                if (start) begin
                    {rem, quo} <= div_step('0, dividend, divisor);
                    dvs        <= divisor;
                    cnt        <= CNT_W'(W - 1);
                    busy       <= 1'b1;
                end
            end else begin
                {rem, quo} <= div_step(rem, quo, dvs);
                cnt        <= cnt - CNT_W'(1);
                if (cnt == CNT_W'(1)) begin
                    busy <= 1'b0;
                    done <= 1'b1;
                end
            end
        end
    end

    assign quotient = quo;

endmodule

// File: rtl/fre_generate.sv
// Programmable square wave from a kHz request: DIV_W-cycle division, then clk_o toggles every half_cnt_o cycles; ready is low only while dividing.
// FRE_GEN_ROUND_EN selects round-to-nearest half-period instead of truncation; new rates take effect on a toggle boundary.
module fre_generate
    import fre_pkg::*;
#(
    parameter int SYS_CLK_FRE = 100_000_000,
    parameter int DIV_W       = DIV_W_DEF
) (
    input  logic             sys_clk_i,
    input  logic             rst_i,
    fre_generate_if.slave    cfg,
    output logic             clk_o,
    output logic             rise_o,
    output logic             run_o,
    output logic             err_o,
    output logic [DIV_W-1:0] half_cnt_o
);

    fre_state_t       state;
    logic [DIV_W-1:0] hcnt;
    logic [DIV_W-1:0] pend;
    logic             pend_vld;

    logic             accept;
    logic             freq_zero;
    logic             tick;
    logic [DIV_W-1:0] divisor;
    logic [DIV_W-1:0] dividend;
    logic             div_done;
    logic [DIV_W-1:0] quotient;

    assign cfg.cfg_ready_o = (state != DIV);
    assign accept          = cfg.cfg_valid_i && cfg.cfg_ready_o;
    assign freq_zero       = (cfg.freq_khz_i == '0);
    assign tick            = run_o && (hcnt == half_cnt_o);

    assign divisor = DIV_W'(cfg.freq_khz_i) * DIV_W'(KHZ_X2);
`ifdef FRE_GEN_ROUND_EN
    // Adding half the divisor turns the truncating divide into round-to-nearest.
    assign dividend = DIV_W'(SYS_CLK_FRE) + DIV_W'(cfg.freq_khz_i) * DIV_W'(KHZ_X1);
`else
    assign dividend = DIV_W'(SYS_CLK_FRE);
`endif

    fre_div_seq #(.W(DIV_W)) u_div (
        .clk      (sys_clk_i),
        .rst      (rst_i),
        .start    (accept && !freq_zero),
        .dividend (dividend),
        .divisor  (divisor),
        .done     (div_done),
        .quotient (quotient)
    );

    always_ff @(posedge sys_clk_i) begin
        if (rst_i) begin
            state      <= IDLE;
            clk_o      <= 1'b0;
            rise_o     <= 1'b0;
            run_o      <= 1'b0;
            err_o      <= 1'b0;
            half_cnt_o <= '0;
            hcnt       <= '0;
            pend       <= '0;
            pend_vld   <= 1'b0;
        end else begin
            rise_o <= 1'b0;

            // The waveform keeps running through DIV; a pending rate only swaps in on a toggle.
            if (tick) begin
                clk_o  <= ~clk_o;
                rise_o <= ~clk_o;
                hcnt   <= DIV_W'(1);
                if (pend_vld) begin
                    half_cnt_o <= pend;
                    pend_vld   <= 1'b0;
                end
            end else if (run_o) begin
                hcnt <= hcnt + DIV_W'(1);
            end

            case (state)
                IDLE, RUN: begin
                    if (accept) begin
                        err_o <= 1'b0;
                        if (freq_zero) begin
                            state      <= IDLE;
                            clk_o      <= 1'b0;
                            rise_o     <= 1'b0;
                            run_o      <= 1'b0;
                            half_cnt_o <= '0;
                            hcnt       <= '0;
                            pend_vld   <= 1'b0;
                        end else begin
                            state <= DIV;
                        end
                    end
                end
                DIV: begin
                    if (div_done) begin
                        if (quotient == '0) begin
                            err_o <= 1'b1;
                            state <= run_o ? RUN : IDLE;
                        end else if (!run_o) begin
                            state      <= RUN;
                            clk_o      <= 1'b1;
                            rise_o     <= 1'b1;
                            run_o      <= 1'b1;
                            half_cnt_o <= quotient;
                            hcnt       <= DIV_W'(1);
                        end else begin
                            state    <= RUN;
                            pend     <= quotient;
                            pend_vld <= 1'b1;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_fre_generate.sv
// Scoreboard bench: the driver pushes the reference outcome of every accepted request, a monitor pops it at the DUT response.
// Free-running checkers verify level lengths and rise strobes; stimulus is directed scenarios followed by random requests.
module tb_fre_generate;
    import fre_pkg::*;

    localparam int SYS = 100_000_000;
    localparam int W   = 32;

    logic         sys_clk = 1'b0;
    logic         rst     = 1'b1;
    logic         clk_o, rise_o, run_o, err_o;
    logic [W-1:0] half_cnt_o;

    fre_generate_if ifc ();

    fre_generate #(.SYS_CLK_FRE(SYS), .DIV_W(W)) dut (
        .sys_clk_i  (sys_clk),
        .rst_i      (rst),
        .cfg        (ifc),
        .clk_o      (clk_o),
        .rise_o     (rise_o),
        .run_o      (run_o),
        .err_o      (err_o),
        .half_cnt_o (half_cnt_o)
    );

    always #5 sys_clk = ~sys_clk;

    typedef struct {
        bit     zero;
        bit     err;
        bit     run;
        longint half;
    } exp_t;

    exp_t   sb[$];
    int     tests = 0;
    int     fails = 0;
    longint m_half = 0;
    bit     m_run  = 1'b0;

    task automatic check(input string name, input logic [63:0] act, input longint exp);
        tests++;
        if (act !== 64'(exp)) begin
            fails++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    // Half-period from the frequency definition: SYS / (2 * f_hz), truncated or rounded.
    function automatic longint ref_half(input int f);
        longint num;
        num = SYS;
`ifdef FRE_GEN_ROUND_EN
        num = num + longint'(f) * 1000;
`endif
        return num / (longint'(f) * 2000);
    endfunction

    task automatic send(input int f, input bit wait_done);
        bit     acc = 1'b0;
        bit     r;
        int     n = 0;
        longint q;
        longint target = -1;
        longint old;
        exp_t   e;
        ifc.cfg_valid_i = 1'b1;
        ifc.freq_khz_i  = f[19:0];
        while (!acc && n < 200) begin
            r = ifc.cfg_ready_o;
            @(posedge sys_clk);
            #1;
            acc = r;
            n++;
        end
        ifc.cfg_valid_i = 1'b0;
        check("accept", 64'(acc), 1);
        e.zero = (f == 0);
        old    = m_half;
        if (f == 0) begin
            e.err = 1'b0; e.run = 1'b0; e.half = 0;
            m_half = 0; m_run = 1'b0;
        end else begin
            q = ref_half(f);
            if (q == 0) begin
                e.err = 1'b1; e.run = m_run; e.half = m_half;
            end else if (!m_run) begin
                e.err = 1'b0; e.run = 1'b1; e.half = q;
                m_half = q; m_run = 1'b1;
            end else begin
                e.err = 1'b0; e.run = 1'b1; e.half = m_half;
                target = q; m_half = q;
            end
        end
        sb.push_back(e);
        if (f != 0 && wait_done) begin
            n = 0;
            while (!ifc.cfg_ready_o && n < 100) begin
                @(posedge sys_clk);
                #1;
                n++;
            end
            check("ready_low_cycles", 64'(n), W);
            if (target >= 0) begin
                n = 0;
                while (half_cnt_o != W'(target) && n < 2 * old + 10) begin
                    @(posedge sys_clk);
                    #1;
                    n++;
                end
                check("pending_load", 64'(half_cnt_o), target);
            end
        end
    endtask

    // Monitor: pop on every DUT response and run the waveform checkers.
    bit     rst_last = 1'b1;
    bit     acc_zero_last = 1'b0;
    logic   ready_prev = 1'b1;
    logic   clk_prev = 1'b0;
    exp_t   me;
    bit     trk = 1'b0;
    int     lvl_len = 0;
    longint lvl_half = 0;
    logic   lvl_clk = 1'b0;

    always @(posedge sys_clk) begin
        rst_last      <= rst;
        acc_zero_last <= ifc.cfg_valid_i && ifc.cfg_ready_o && (ifc.freq_khz_i == '0) && !rst;
    end

    always @(negedge sys_clk) begin
        if (!rst_last && (acc_zero_last || (!ready_prev && ifc.cfg_ready_o))) begin
            if (sb.size() == 0) begin
                tests++;
                fails++;
                $display("FAIL unexpected_response: got half %0d with no request outstanding", half_cnt_o);
            end else begin
                me = sb.pop_front();
                check("resp_err", 64'(err_o), me.err);
                check("resp_run", 64'(run_o), me.run);
                check("resp_half", 64'(half_cnt_o), me.half);
                if (me.zero) check("resp_clk_stopped", 64'(clk_o), 0);
            end
        end
        ready_prev = ifc.cfg_ready_o;

        if (rise_o || (clk_o && !clk_prev))
            check("rise_strobe", 64'(rise_o), longint'(clk_o && !clk_prev));
        if (!run_o && clk_o)
            check("clk_low_when_stopped", 64'(clk_o), 0);
        clk_prev = clk_o;

        if (rst_last || !run_o) begin
            trk = 1'b0;
        end else if (!trk) begin
            trk = 1'b1; lvl_len = 1; lvl_half = longint'(half_cnt_o); lvl_clk = clk_o;
        end else if (clk_o != lvl_clk) begin
            check("level_len", 64'(lvl_len), lvl_half);
            lvl_len = 1; lvl_half = longint'(half_cnt_o); lvl_clk = clk_o;
        end else begin
            lvl_len++;
        end
    end

    initial begin
        #800_000;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        int sel;
        int f;
        ifc.cfg_valid_i = 1'b0;
        ifc.freq_khz_i  = '0;
        rst = 1'b1;
        repeat (3) @(posedge sys_clk);
        #1;
        check("rst_clk", 64'(clk_o), 0);
        check("rst_rise", 64'(rise_o), 0);
        check("rst_run", 64'(run_o), 0);
        check("rst_err", 64'(err_o), 0);
        check("rst_half", 64'(half_cnt_o), 0);
        check("rst_ready", 64'(ifc.cfg_ready_o), 1);
        rst = 1'b0;
        repeat (2) @(posedge sys_clk);
        #1;

        send(1000, 1);
        repeat (300) @(posedge sys_clk);
        #1;
        send(30000, 1);
        repeat (20) @(posedge sys_clk);
        #1;
        send(1000, 1);
        repeat (120) @(posedge sys_clk);
        #1;
        send(60000, 1);
        repeat (150) @(posedge sys_clk);
        #1;
        send(500, 1);
        repeat (250) @(posedge sys_clk);
        #1;
        send(1000, 1);
        n = 0;
        while (!rise_o && n < 300) begin
            @(posedge sys_clk);
            #1;
            n++;
        end
        check("rise_seen", 64'(rise_o), 1);
        repeat (10) @(posedge sys_clk);
        #1;
        send(2000, 1);
        repeat (150) @(posedge sys_clk);
        #1;
        send(0, 1);
        repeat (5) @(posedge sys_clk);
        #1;

        // Reset in the middle of a division.
        send(1000, 0);
        repeat (10) @(posedge sys_clk);
        #1;
        rst = 1'b1;
        @(posedge sys_clk);
        #1;
        check("mid_div_rst_clk", 64'(clk_o), 0);
        check("mid_div_rst_run", 64'(run_o), 0);
        check("mid_div_rst_half", 64'(half_cnt_o), 0);
        check("mid_div_rst_ready", 64'(ifc.cfg_ready_o), 1);
        rst = 1'b0;
        sb.delete();
        m_half = 0;
        m_run  = 1'b0;
        send(1000, 1);
        repeat (200) @(posedge sys_clk);
        #1;
        send(0, 1);
        repeat (3) @(posedge sys_clk);
        #1;

        // Valid held high across a division: the second request waits for ready.
        send(1000, 0);
        send(500, 1);
        repeat (100) @(posedge sys_clk);
        #1;

        for (int i = 0; i < 14; i++) begin
            sel = $urandom_range(0, 9);
            if (sel == 0)      f = 0;
            else if (sel == 1) f = $urandom_range(50001, 1048575);
            else               f = $urandom_range(200, 60000);
            send(f, 1);
            repeat ($urandom_range(0, 300)) @(posedge sys_clk);
            #1;
        end

        send(0, 1);
        repeat (5) @(posedge sys_clk);
        #1;
        check("sb_drained", 64'(sb.size()), 0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/fre_generate.md
Name: fre_generate

Overview:
- Programmable square-wave generator and the transmit-side counterpart of the team's frequency measurement block.
- Accepts a target frequency in kHz (same 20-bit kHz units the measurement block reports).
- Computes a half-period count in sys_clk_i cycles with a sequential divider and toggles clk_o.
- Feeding clk_o into the measurement block closes a self-test loop on the board.

Parameters:
- SYS_CLK_FRE, 100_000_000: sys_clk_i frequency in Hz.
- DIV_W, 32: divider and half-period counter width; must hold SYS_CLK_FRE and 2000*(2^20-1).

Ports:
- sys_clk_i  input  1  system clock; all logic is on its rising edge.
- rst_i  input  1  reset, synchronous and active-high.
- cfg_valid_i  input  1  new frequency request valid.
- cfg_ready_o  output  1  request can be accepted this cycle.
- freq_khz_i  input  20  requested frequency in kHz; 0 means stop.
- clk_o  output  1  generated square wave, registered.
- rise_o  output  1  one-cycle strobe in the cycle clk_o goes 0->1.
- run_o  output  1  generator is toggling.
- err_o  output  1  last request was unreachable; sticky.
- half_cnt_o  output  DIV_W  active half-period in sys_clk_i cycles; 0 when stopped.

Behaviour:
- Reset: clk_o=0, rise_o=0, run_o=0, err_o=0, half_cnt_o=0, cfg_ready_o=1, FSM=IDLE. Reset overrides everything, including mid-division and mid-period.
- Handshake: a request is accepted when cfg_valid_i and cfg_ready_o are both high. freq_khz_i is sampled in that cycle. cfg_ready_o is high in IDLE and RUN and low in DIV.
- FSM states: IDLE (stopped), DIV (dividing), RUN (toggling).
- Accept with freq_khz_i=0: go to IDLE next cycle. clk_o forced 0, run_o=0, half_cnt_o=0, err_o cleared. No division is performed.
- Accept with freq_khz_i>0: enter DIV; err_o cleared.
  - Divisor = freq_khz_i*2000 (DIV_W bits); dividend = SYS_CLK_FRE.
  - Restoring divider, one quotient bit per cycle.
  - Quotient valid exactly DIV_W cycles after acceptance.
- DIV outcome, quotient==0 (requested frequency > SYS_CLK_FRE/2): err_o=1. Return to the previous state (IDLE or RUN); the old half-period and old waveform are unchanged.
- DIV outcome, quotient>0: the quotient becomes the pending half-period.
  - From IDLE: next cycle clk_o=1, rise_o=1, run_o=1, half_cnt_o=quotient, half counter=1.
  - From RUN: the old waveform continues during DIV. The pending value is loaded at the next toggle boundary, so no runt pulse occurs.
- RUN: the half counter counts 1..half_cnt_o. When it equals half_cnt_o, clk_o toggles and the counter returns to 1. Each level therefore lasts exactly half_cnt_o cycles.
  - Output frequency = SYS_CLK_FRE/(2*half_cnt_o).
  - rise_o is high only in the cycle clk_o becomes 1.
- DIV while stopped: clk_o stays 0.
- Rounding: truncating quotient unless the optional feature is enabled.
- cfg_valid_i held high during DIV is ignored; the request is accepted once cfg_ready_o returns high.

Optional Feature:
- FRE_GEN_ROUND_EN defined: dividend = SYS_CLK_FRE + freq_khz_i*1000, i.e. round-to-nearest of SYS_CLK_FRE/(2*f). Latency is unchanged.
- Undefined: truncating division.
- The quotient==0 error rule applies to the final quotient in both cases.

Decomposition:
- fre_pkg holds: DIV_W default, KHZ_X2 = 2000, and the FSM state typedef (IDLE, DIV, RUN).
- One sub-module, fre_div_seq: unsigned restoring divider with ports start, dividend, divisor, done (1-cycle pulse), quotient. Fixed latency DIV_W cycles; start is ignored while busy.

Test Plan (SYS_CLK_FRE=100_000_000, DIV_W=32):
- Accept freq_khz_i=1000 from IDLE -> cfg_ready_o low for 32 cycles. Then half_cnt_o=50, clk_o period 100 cycles, 50 high/50 low, rise_o every 100 cycles.
- Accept 30000 -> half_cnt_o=1 (50 MHz toggle). With FRE_GEN_ROUND_EN -> half_cnt_o=2.
- While running at 1000, accept 60000 -> err_o=1, half_cnt_o stays 50, and clk_o continues without disturbance. A later accept of 500 clears err_o and gives half_cnt_o=100.
- While running at 1000, accept 2000 mid-high-phase -> current high phase completes at 50 cycles, then levels of 25 cycles. No level shorter than 25 cycles occurs.
- Accept 0 while running -> next cycle clk_o=0, run_o=0, half_cnt_o=0.
- Assert rst_i 10 cycles into DIV -> all outputs at reset values next cycle, cfg_ready_o=1. A following accept of 1000 behaves as in the first scenario.
